rx_dma_writer: RTL and testbench

//  Upstream write controller for the RX buffer memory. Accepts a programmed transfer
//  (base address, byte count) and a byte stream from the serial RX front end.

---
 rtl/dma_pkg.sv | 13 +
 rtl/dma_addr_counter.sv | 28 ++
 rtl/rx_dma_writer.sv | 114 +++++++++++
 tb/tb_rx_dma_writer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the RX/TX DMA blocks: controller state encoding and default sizes.
package dma_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dma_addr_counter.sv
// Loadable memory address counter that wraps to zero after DEPTH-1.
module dma_addr_counter
    import dma_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(DEPTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (inc) begin
            q <= (q == LAST) ? '0 : q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/rx_dma_writer.sv
// RX buffer write controller: turns a programmed (base, length) transfer plus a byte
// strobe stream into registered memory writes, with done/cfg_err/drop_err reporting.
module rx_dma_writer
    import dma_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base_addr,
    input  logic [WIDTH-1:0] xfer_len,
    input  logic             abort,
    input  logic             rx_valid,
    input  logic [WIDTH-1:0] rx_byte,
    output logic             mem_wr_en,
    output logic [WIDTH-1:0] rx_mem_addr,
    output logic [WIDTH-1:0] data_rx_in,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic             drop_err,
    output logic [WIDTH-1:0] byte_cnt
);

    localparam logic [WIDTH:0] DEPTH_LIM = (WIDTH + 1)'(DEPTH);

    state_t           state, state_next;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] remaining;
    logic             start_ok, cfg_bad, load, wr_fire, drop_set;

    dma_addr_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_addr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .inc   (wr_fire),
        .d     (base_addr),
        .q     (addr)
    );

    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        cfg_bad    = 1'b0;
        load       = 1'b0;
        wr_fire    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if ({1'b0, base_addr} >= DEPTH_LIM) begin
                        cfg_bad = 1'b1;
                    end else begin
                        start_ok = 1'b1;
                        if (xfer_len == '0) begin
                            state_next = ST_DONE;
                        end else begin
                            state_next = ST_XFER;
                            load       = 1'b1;
                        end
                    end
                end
            end
            ST_XFER: begin
                // Abort takes priority: a strobe in the abort cycle is discarded.
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (rx_valid) begin
                    wr_fire = 1'b1;
                    if (remaining == WIDTH'(1)) state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign drop_set = rx_valid && (state != ST_XFER);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            remaining   <= '0;
            mem_wr_en   <= 1'b0;
            rx_mem_addr <= '0;
            data_rx_in  <= '0;
            cfg_err     <= 1'b0;
            drop_err    <= 1'b0;
            byte_cnt    <= '0;
        end else begin
            state     <= state_next;
            mem_wr_en <= wr_fire;
            cfg_err   <= cfg_bad;
            if (wr_fire) begin
                rx_mem_addr <= addr;
                data_rx_in  <= rx_byte;
                remaining   <= remaining - WIDTH'(1);
                byte_cnt    <= byte_cnt + WIDTH'(1);
            end
            if (start_ok) byte_cnt <= '0;
            if (load) remaining <= xfer_len;
            // A same-cycle drop beats the clear from an accepted start.
            if (drop_set) begin
                drop_err <= 1'b1;
            end else if (start_ok) begin
                drop_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx_dma_writer.sv
// Directed bench for rx_dma_writer with a write scoreboard checked on every memory write.
module tb_rx_dma_writer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, abort, rx_valid;
    logic [W-1:0] base_addr, xfer_len, rx_byte;
    logic         mem_wr_en, busy, done, cfg_err, drop_err;
    logic [W-1:0] rx_mem_addr, data_rx_in, byte_cnt;

    typedef struct packed {
        logic [W-1:0] addr;
        logic [W-1:0] data;
        logic         last;
    } wr_t;

    wr_t sb[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  n_wr = 0;
    int  n_done = 0;

    rx_dma_writer #(.WIDTH(8), .DEPTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .xfer_len    (xfer_len),
        .abort       (abort),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .mem_wr_en   (mem_wr_en),
        .rx_mem_addr (rx_mem_addr),
        .data_rx_in  (data_rx_in),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .drop_err    (drop_err),
        .byte_cnt    (byte_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write must match the next expected entry; done must coincide with the last.
    always @(negedge clk) begin
        if (done === 1'b1) n_done++;
        if (mem_wr_en === 1'b1) begin
            n_wr++;
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'(rx_mem_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", 32'(rx_mem_addr), 32'(e.addr));
                chk("wr_data", 32'(data_rx_in), 32'(e.data));
                chk("wr_done", 32'(done), 32'(e.last));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; abort = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic do_start(input logic [W-1:0] b, input logic [W-1:0] l);
        start = 1'b1; base_addr = b; xfer_len = l;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] b, input logic [W-1:0] a, input logic last);
        wr_t e;
        rx_valid = 1'b1; rx_byte = b;
        e.addr = a; e.data = b; e.last = last;
        sb.push_back(e);
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        int d0, w0;
        rst_n = 1'b0; base_addr = '0; xfer_len = '0; rx_byte = '0;
        idle_inputs();
        repeat (3) tick();
        chk("rst_outputs", {mem_wr_en, busy, done, cfg_err, drop_err, 27'd0},
            32'd0);
        chk("rst_addr_data_cnt", {8'd0, rx_mem_addr, data_rx_in, byte_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: base 2, len 3, spaced bytes
        d0 = n_done;
        do_start(8'd2, 8'd3);
        chk("t1_busy", 32'(busy), 32'd1);
        send(8'hA1, 8'd2, 1'b0); tick();
        send(8'hB2, 8'd3, 1'b0); tick();
        send(8'hC3, 8'd4, 1'b1);
        tick(); tick();
        chk("t1_byte_cnt", 32'(byte_cnt), 32'd3);
        chk("t1_done_count", 32'(n_done - d0), 32'd1);
        chk("t1_idle", 32'(busy), 32'd0);

        // 2: wrap across DEPTH with back-to-back strobes
        w0 = n_wr;
        do_start(8'd6, 8'd4);
        send(8'h10, 8'd6, 1'b0);
        send(8'h11, 8'd7, 1'b0);
        send(8'h12, 8'd0, 1'b0);
        send(8'h13, 8'd1, 1'b1);
        tick(); tick();
        chk("t2_writes", 32'(n_wr - w0), 32'd4);
        chk("t2_byte_cnt", 32'(byte_cnt), 32'd4);

        // 3: zero-length transfer
        w0 = n_wr; d0 = n_done;
        do_start(8'd1, 8'd0);
        @(negedge clk);
        chk("t3_busy", 32'(busy), 32'd1);
        chk("t3_done", 32'(done), 32'd1);
        tick(); @(negedge clk);
        chk("t3_busy_after", 32'(busy), 32'd0);
        chk("t3_writes", 32'(n_wr - w0), 32'd0);
        chk("t3_done_count", 32'(n_done - d0), 32'd1);

        // 4: abort together with a strobe
        d0 = n_done;
        do_start(8'd5, 8'd5);
        send(8'h21, 8'd5, 1'b0);
        send(8'h22, 8'd6, 1'b0);
        rx_valid = 1'b1; rx_byte = 8'h23; abort = 1'b1;
        tick();
        idle_inputs();
        tick(); tick();
        chk("t4_byte_cnt", 32'(byte_cnt), 32'd2);
        chk("t4_idle", 32'(busy), 32'd0);
        chk("t4_no_done", 32'(n_done - d0), 32'd0);

        // 5: drop in IDLE, cleared by start; bad base rejected
        w0 = n_wr;
        rx_valid = 1'b1; rx_byte = 8'h55;
        tick();
        rx_valid = 1'b0;
        @(negedge clk);
        chk("t5_drop_set", 32'(drop_err), 32'd1);
        chk("t5_no_write", 32'(n_wr - w0), 32'd0);
        tick();
        do_start(8'd0, 8'd1);
        chk("t5_drop_clr", 32'(drop_err), 32'd0);
        send(8'h66, 8'd0, 1'b1);
        tick(); tick();
        do_start(8'd9, 8'd2);
        @(negedge clk);
        chk("t5_cfg_err", 32'(cfg_err), 32'd1);
        chk("t5_cfg_idle", 32'(busy), 32'd0);
        tick(); @(negedge clk);
        chk("t5_cfg_pulse", 32'(cfg_err), 32'd0);

        // 6: reset mid-transfer
        do_start(8'd3, 8'd4);
        send(8'h77, 8'd3, 1'b0);
        tick();
        rx_valid = 1'b1; rx_byte = 8'h78;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_flags", {mem_wr_en, busy, done, cfg_err, drop_err, 27'd0}, 32'd0);
        chk("t6_rst_data", {8'd0, rx_mem_addr, data_rx_in, byte_cnt}, 32'd0);
        tick(); tick();
        rx_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        w0 = n_wr;
        rx_valid = 1'b1; rx_byte = 8'h79;
        tick(); tick();
        rx_valid = 1'b0;
        tick(); tick();
        chk("t6_no_writes", 32'(n_wr - w0), 32'd0);
        chk("t6_idle", 32'(busy), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
